// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: ALU operation classes, funct3
// encodings, internal ALU control codes and execute FSM state encodings.
package riscv_pkg;

  // Operation class supplied by the decoder
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // funct3 for register/immediate ALU instructions
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 for conditional branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } exec_state_t;

  // Map operation class plus funct fields onto an internal ALU control code
  function automatic alu_ctrl_t decode_alu_ctrl(input logic [1:0] alu_op,
                                                input logic [2:0] funct3,
                                                input logic       funct7b5);
    alu_ctrl_t ctrl;
    case (alu_op)
      ALUOP_ADD:    ctrl = ALU_ADD;
      ALUOP_BRANCH: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADD_SUB: ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_SLL:     ctrl = ALU_SLL;
          F3_SLT:     ctrl = ALU_SLT;
          F3_SLTU:    ctrl = ALU_SLTU;
          F3_XOR:     ctrl = ALU_XOR;
          F3_SRL_SRA: ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          F3_OR:      ctrl = ALU_OR;
          F3_AND:     ctrl = ALU_AND;
          default:    ctrl = ALU_ADD;
        endcase
      end
      default:      ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/execute_mul.sv
// Iterative radix-2 shift-add multiplier returning the low XLEN bits of the
// product. One step per cycle for exactly XLEN cycles after start; abort and
// reset discard any partial product.
module execute_mul #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            busy,
  output logic            last,
  output logic [XLEN-1:0] product
);
  import riscv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  a_r;
  logic [XLEN-1:0]  b_r;
  logic [XLEN-1:0]  acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             last_s;

  assign last_s  = busy_r && (cnt_r == CNT_W'(XLEN - 1));
  assign busy    = busy_r;
  assign last    = last_s;
  assign product = acc_r;

  // Load operands on start, then add the shifted multiplicand per multiplier bit
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      a_r    <= {XLEN{1'b0}};
      b_r    <= {XLEN{1'b0}};
      acc_r  <= {XLEN{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (start) begin
      a_r    <= multiplicand;
      b_r    <= multiplier;
      acc_r  <= {XLEN{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b1;
    end else if (busy_r) begin
      acc_r  <= b_r[0] ? (acc_r + a_r) : acc_r;
      a_r    <= a_r << 1;
      b_r    <= b_r >> 1;
      cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      busy_r <= !last_s;
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Handshaked execute stage: ALU result, branch decision and branch target
// held in a registered output slot. Defining RV_MUL_EN adds the iterative
// MUL operation (execute_mul) behind the same valid/ready handshake.
module execute_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      in_alu_op,
  input  logic            in_alu_src,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic            in_funct7b0,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_branch_taken,
  output logic [XLEN-1:0] out_pc_branch
);
  import riscv_pkg::*;

  localparam int SHW = $clog2(XLEN);

  exec_state_t     state_r;
  logic [XLEN-1:0] mul_pc_r;

  logic [XLEN-1:0] op_b_s;
  logic [SHW-1:0]  shamt_s;
  alu_ctrl_t       alu_ctrl_s;
  logic [XLEN-1:0] alu_res_s;
  logic [XLEN-1:0] exec_res_s;
  logic [XLEN-1:0] pc_branch_s;
  logic            eq_s;
  logic            lt_s;
  logic            ltu_s;
  logic            taken_s;
  logic            accept_s;
  logic            is_mul_s;
  logic            mul_last_s;
  logic [XLEN-1:0] mul_product_s;

  assign op_b_s      = in_alu_src ? in_imm : in_rs2;
  assign shamt_s     = op_b_s[SHW-1:0];
  assign eq_s        = (in_rs1 == op_b_s);
  assign lt_s        = ($signed(in_rs1) < $signed(op_b_s));
  assign ltu_s       = (in_rs1 < op_b_s);
  assign pc_branch_s = in_pc + in_imm;
  assign alu_ctrl_s  = decode_alu_ctrl(in_alu_op, in_funct3, in_funct7b5);

  assign in_ready = (state_r == ST_IDLE) && (!out_valid || out_ready) && !flush && !reset;
  assign accept_s = in_valid && in_ready;

  // ALU datapath on the offered operands
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    case (alu_ctrl_s)
      ALU_ADD:  alu_res_s = in_rs1 + op_b_s;
      ALU_SUB:  alu_res_s = in_rs1 - op_b_s;
      ALU_SLL:  alu_res_s = in_rs1 << shamt_s;
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, ltu_s};
      ALU_XOR:  alu_res_s = in_rs1 ^ op_b_s;
      ALU_SRL:  alu_res_s = in_rs1 >> shamt_s;
      ALU_SRA:  alu_res_s = $unsigned($signed(in_rs1) >>> shamt_s);
      ALU_OR:   alu_res_s = in_rs1 | op_b_s;
      ALU_AND:  alu_res_s = in_rs1 & op_b_s;
      default:  alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Branch condition, only meaningful for the branch operation class
  always_comb begin
    taken_s = 1'b0;
    if (in_alu_op == ALUOP_BRANCH) begin
      case (in_funct3)
        F3_BEQ:  taken_s = eq_s;
        F3_BNE:  taken_s = !eq_s;
        F3_BLT:  taken_s = lt_s;
        F3_BGE:  taken_s = !lt_s;
        F3_BLTU: taken_s = ltu_s;
        F3_BGEU: taken_s = !ltu_s;
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
  end

`ifdef RV_MUL_EN
  logic is_m_s;

  assign is_m_s     = (in_alu_op == ALUOP_RTYPE) && in_funct7b0;
  assign is_mul_s   = is_m_s && (in_funct3 == F3_ADD_SUB);
  // Any funct7b0 encoding besides MUL yields a zero result
  assign exec_res_s = is_m_s ? {XLEN{1'b0}} : alu_res_s;

  execute_mul #(.XLEN(XLEN)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .abort        (flush),
    .start        (accept_s && is_mul_s),
    .multiplicand (in_rs1),
    .multiplier   (in_rs2),
    .busy         (),
    .last         (mul_last_s),
    .product      (mul_product_s)
  );
`else
  logic unused_funct7b0_s;

  assign unused_funct7b0_s = in_funct7b0;
  assign is_mul_s          = 1'b0;
  assign exec_res_s        = alu_res_s;
  assign mul_last_s        = 1'b0;
  assign mul_product_s     = {XLEN{1'b0}};
`endif

  // Control FSM and output register: drain, single-cycle load, MUL sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      mul_pc_r         <= {XLEN{1'b0}};
      out_valid        <= 1'b0;
      out_result       <= {XLEN{1'b0}};
      out_zero         <= 1'b0;
      out_branch_taken <= 1'b0;
      out_pc_branch    <= {XLEN{1'b0}};
    end else if (flush) begin
      state_r   <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s && is_mul_s) begin
            state_r  <= ST_MUL_BUSY;
            mul_pc_r <= pc_branch_s;
          end else if (accept_s) begin
            out_valid        <= 1'b1;
            out_result       <= exec_res_s;
            out_zero         <= (exec_res_s == {XLEN{1'b0}});
            out_branch_taken <= taken_s;
            out_pc_branch    <= pc_branch_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_last_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_MUL_BUSY;
          end
        end
        ST_DONE: begin
          if (!out_valid || out_ready) begin
            state_r          <= ST_IDLE;
            out_valid        <= 1'b1;
            out_result       <= mul_product_s;
            out_zero         <= (mul_product_s == {XLEN{1'b0}});
            out_branch_taken <= 1'b0;
            out_pc_branch    <= mul_pc_r;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
